hw_countdown_timer: RTL
=======================

Name: hw_countdown_timer

Overview:
- Hardware countdown timer that drives the board I/O the HPS/Nios system exposes: six 7-segment digits, three LEDs and a buzzer.
- Inputs are the four push-buttons and four switches; the block debounces them itself.
- Digits show HH:MM:SS on seg5..seg0. Buttons set, start, pause and clear the timer. Expiry sounds the buzzer.

Parameters:
- CLK_HZ, 50000000, clk_clk frequency; the 1 Hz tick prescaler counts to CLK_HZ-1.
- DEBOUNCE_CYCLES, 500000, cycles a synchronized button must be stable before it is accepted.
- BUZZ_HALF_CYCLES, 25000, buzzer square-wave half period in cycles (1 kHz at 50 MHz).
- ALARM_SEC, 5, seconds ALARM lasts before auto-return to IDLE.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- botones  in  4  raw push-buttons, active-low, asynchronous. [0] start/pause, [1] clear, [2] increment, [3] decrement.
- swtich  in  4  raw switches. [1:0] field select (00 sec, 01 min, 10 hour, 11 none). [2] reserved. [3] buzzer mute.
- buzzer  out  1  buzzer drive.
- led  out  3  [0] RUN, [1] PAUSE, [2] ALARM.
- seg0..seg5  out  7 each  active-low segments {g,f,e,d,c,b,a}. seg0 = seconds units … seg5 = hours tens.

Behaviour:
- Clock and reset: one clock, clk_clk; reset_reset is asynchronous and active-high.
- Reset values:
  - State IDLE; time 00:00:00.
  - seg0..seg5 = 7'b1000000 (digit 0); led = 3'b000; buzzer = 0.
  - Prescaler, buzzer and alarm counters = 0; debouncers hold the released level.
- Button conditioning, per bit:
  - 2-FF synchronizer, then a stability counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A press event is a 1-cycle pulse on the debounced 1->0 edge.
  - Latency from a stable raw edge to the pulse is DEBOUNCE_CYCLES+3 cycles.
  - Switches: 2-FF synchronized only.
- Time registers are BCD: hours 00-23, minutes 00-59, seconds 00-59.
- Event priority when several press pulses occur in one cycle: clear > start/pause > inc > dec. Only the highest-priority event is acted on.
- FSM IDLE:
  - inc/dec adjusts the selected field with wrap (59->00, 00->59; hours 23->00, 00->23).
  - Field select 11: inc/dec are ignored.
  - Start with time 00:00:00 is ignored.
  - Start with nonzero time -> RUN, prescaler cleared.
- FSM RUN:
  - On each tick (prescaler == CLK_HZ-1), decrement by 1 s with BCD borrow across fields.
  - A tick producing 00:00:00 -> ALARM in the same cycle.
  - start -> PAUSE; clear -> IDLE with time 00:00:00.
  - inc/dec are ignored.
  - A tick coinciding with a start or clear event is discarded.
- FSM PAUSE:
  - Time is held and the prescaler is frozen.
  - start -> RUN with the prescaler cleared, so the next decrement is a full second after resume.
  - clear -> IDLE with time zeroed; inc/dec adjust the time as in IDLE.
  - If inc/dec leaves 00:00:00, the next start is ignored.
- FSM ALARM:
  - buzzer toggles every BUZZ_HALF_CYCLES cycles, forced 0 while swtich[3] = 1.
  - Counts ALARM_SEC ticks, then -> IDLE.
  - Any press event -> IDLE immediately.
  - buzzer = 0 in the cycle the state leaves ALARM.
- Outputs:
  - led is decoded from the state and registered.
  - Segments are registered: a time change appears on the segments 1 cycle later.
  - Blanking is never used.
- Reset mid-operation: all state returns to reset values immediately, regardless of the clock.

Decomposition:
- Package hw_timer_pkg holds:
  - the state enum {IDLE, RUN, PAUSE, ALARM};
  - the field-select constants;
  - the BCD limit constants;
  - a function bcd_to_seg (4-bit digit to active-low 7-bit pattern).
- Sub-module button_conditioner (parameter DEBOUNCE_CYCLES): one instance per button, outputs the debounced level and the press pulse.

Test Plan (CLK_HZ=20, DEBOUNCE_CYCLES=4, BUZZ_HALF_CYCLES=2, ALARM_SEC=2):
- Reset, then press dec with swtich=01 -> minutes 59, seg3 = 7'b0010010, seg2 = 7'b0010000; a 2-cycle glitch on botones[2] produces no change.
- Set 00:00:03, press start -> led=001; after 20/40/60 cycles the display shows 02/01/00, then ALARM with led=100 and buzzer toggling every 2 cycles; after 40 more cycles -> IDLE, buzzer=0.
- Start with time 00:00:00 -> stays IDLE, led=000.
- Set 00:01:00, RUN, one tick -> 00:00:59 (borrow). Press start -> PAUSE, led=010, time held for 100 cycles. Resume -> next decrement exactly 20 cycles after the resume pulse.
- Press clear and start debounced in the same cycle during RUN -> IDLE, 00:00:00.
- In ALARM with swtich[3]=1 -> buzzer stays 0. Any press -> IDLE. Assert reset_reset between clock edges during RUN -> outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/hw_timer_pkg.sv
// Shared types, constants and BCD/segment helpers for the countdown timer.
package hw_timer_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StPause, StAlarm} timer_state_e;

    localparam logic [1:0] FieldSec  = 2'b00;
    localparam logic [1:0] FieldMin  = 2'b01;
    localparam logic [1:0] FieldHour = 2'b10;
    localparam logic [1:0] FieldNone = 2'b11;

    localparam logic [7:0] SecMax  = 8'h59;
    localparam logic [7:0] MinMax  = 8'h59;
    localparam logic [7:0] HourMax = 8'h23;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0000110;
        endcase
        return s;
    endfunction

    // Two-digit BCD increment/decrement with wrap between 00 and max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == max) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = max;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Synchronizes and debounces one active-low push-button; emits a 1-cycle press pulse.
module button_conditioner
    import hw_timer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            db_q, db_d;
    logic            db_dly_q;
    logic            press_q;

    // The counter only runs while the synchronized input disagrees with the accepted level.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync_q[1] != db_q) begin
            if (cnt_q == CntMax) begin
                db_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= 2'b11;
            cnt_q    <= '0;
            db_q     <= 1'b1;
            db_dly_q <= 1'b1;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw};
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            db_dly_q <= db_q;
            press_q  <= db_dly_q & ~db_q;
        end
    end

    assign level = db_q;
    assign press = press_q;

endmodule

// File: rtl/hw_countdown_timer.sv
// HH:MM:SS countdown timer with debounced buttons, 7-segment display, status LEDs and buzzer.
module hw_countdown_timer
    import hw_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ           = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES  = 500000,
    parameter int unsigned BUZZ_HALF_CYCLES = 25000,
    parameter int unsigned ALARM_SEC        = 5
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [3:0] botones,
    input  logic [3:0] swtich,
    output logic       buzzer,
    output logic [2:0] led,
    output logic [6:0] seg0,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [6:0] seg3,
    output logic [6:0] seg4,
    output logic [6:0] seg5
);

    localparam int unsigned PrescW = cnt_width(CLK_HZ);
    localparam int unsigned AlarmW = cnt_width(ALARM_SEC);
    localparam int unsigned BuzzW  = cnt_width(BUZZ_HALF_CYCLES);
    localparam logic [PrescW-1:0] PrescMax = PrescW'(CLK_HZ - 1);
    localparam logic [AlarmW-1:0] AlarmMax = AlarmW'(ALARM_SEC - 1);
    localparam logic [BuzzW-1:0]  BuzzMax  = BuzzW'(BUZZ_HALF_CYCLES - 1);

    logic [3:0] btn_level, btn_press;
    logic [3:0] sw_s1_q, sw_s2_q;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk  (clk_clk),
            .rst  (reset_reset),
            .raw  (botones[i]),
            .level(btn_level[i]),
            .press(btn_press[i])
        );
    end

    logic unused_sig;
    assign unused_sig = ^{btn_level, sw_s2_q[2]};

    timer_state_e      state_q, state_d;
    logic [7:0]        sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [PrescW-1:0] presc_q, presc_d;
    logic [AlarmW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic [BuzzW-1:0]  buzz_cnt_q, buzz_cnt_d;
    logic              buzz_ph_q, buzz_ph_d;
    logic              buzzer_d;
    logic [2:0]        led_d;

    logic       ev_clear, ev_start, ev_inc, ev_dec, any_press;
    logic       tick, time_zero, dn_zero;
    logic [1:0] fsel;
    logic       mute;
    logic [7:0] adj_sec, adj_min, adj_hour;
    logic [7:0] dn_sec, dn_min, dn_hour;

    assign fsel = sw_s2_q[1:0];
    assign mute = sw_s2_q[3];

    // Only the highest-priority pending press is acted on.
    assign ev_clear  = btn_press[1];
    assign ev_start  = btn_press[0] & ~btn_press[1];
    assign ev_inc    = btn_press[2] & ~|btn_press[1:0];
    assign ev_dec    = btn_press[3] & ~|btn_press[2:0];
    assign any_press = |btn_press;

    assign tick      = (presc_q == PrescMax);
    assign time_zero = ({hour_q, min_q, sec_q} == 24'h0);
    assign dn_zero   = ({dn_hour, dn_min, dn_sec} == 24'h0);

    always_comb begin
        adj_sec  = sec_q;
        adj_min  = min_q;
        adj_hour = hour_q;
        if (ev_inc || ev_dec) begin
            case (fsel)
                FieldSec:  adj_sec  = ev_inc ? bcd_inc(sec_q, SecMax)   : bcd_dec(sec_q, SecMax);
                FieldMin:  adj_min  = ev_inc ? bcd_inc(min_q, MinMax)   : bcd_dec(min_q, MinMax);
                FieldHour: adj_hour = ev_inc ? bcd_inc(hour_q, HourMax) : bcd_dec(hour_q, HourMax);
                default: ;
            endcase
        end
    end

    // One-second decrement with borrow rippling from seconds into minutes and hours.
    always_comb begin
        dn_sec  = sec_q;
        dn_min  = min_q;
        dn_hour = hour_q;
        if (sec_q != 8'h00) begin
            dn_sec = bcd_dec(sec_q, SecMax);
        end else begin
            dn_sec = SecMax;
            if (min_q != 8'h00) begin
                dn_min = bcd_dec(min_q, MinMax);
            end else begin
                dn_min  = MinMax;
                dn_hour = bcd_dec(hour_q, HourMax);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        presc_d     = presc_q;
        alarm_cnt_d = alarm_cnt_q;
        buzz_cnt_d  = buzz_cnt_q;
        buzz_ph_d   = buzz_ph_q;
        unique case (state_q)
            StIdle: begin
                presc_d = '0;
                if (ev_clear) begin
                    {hour_d, min_d, sec_d} = 24'h0;
                end else if (ev_start) begin
                    if (!time_zero) state_d = StRun;
                end else begin
                    {hour_d, min_d, sec_d} = {adj_hour, adj_min, adj_sec};
                end
            end
            StRun: begin
                if (ev_clear) begin
                    state_d = StIdle;
                    {hour_d, min_d, sec_d} = 24'h0;
                    presc_d = '0;
                end else if (ev_start) begin
                    state_d = StPause;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        {hour_d, min_d, sec_d} = {dn_hour, dn_min, dn_sec};
                        if (dn_zero) begin
                            state_d     = StAlarm;
                            alarm_cnt_d = '0;
                            buzz_cnt_d  = '0;
                            buzz_ph_d   = 1'b0;
                        end
                    end
                end
            end
            StPause: begin
                if (ev_clear) begin
                    state_d = StIdle;
                    {hour_d, min_d, sec_d} = 24'h0;
                    presc_d = '0;
                end else if (ev_start) begin
                    if (!time_zero) begin
                        state_d = StRun;
                        presc_d = '0;
                    end
                end else begin
                    {hour_d, min_d, sec_d} = {adj_hour, adj_min, adj_sec};
                end
            end
            StAlarm: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (buzz_cnt_q == BuzzMax) begin
                    buzz_cnt_d = '0;
                    buzz_ph_d  = ~buzz_ph_q;
                end else begin
                    buzz_cnt_d = buzz_cnt_q + 1'b1;
                end
                if (any_press) begin
                    state_d = StIdle;
                    presc_d = '0;
                end else if (tick) begin
                    if (alarm_cnt_q == AlarmMax) begin
                        state_d = StIdle;
                        presc_d = '0;
                    end else begin
                        alarm_cnt_d = alarm_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        led_d = 3'b000;
        unique case (state_d)
            StIdle:  led_d = 3'b000;
            StRun:   led_d = 3'b001;
            StPause: led_d = 3'b010;
            StAlarm: led_d = 3'b100;
            default: led_d = 3'b000;
        endcase
    end

    assign buzzer_d = (state_d == StAlarm) & buzz_ph_d & ~mute;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sw_s1_q     <= 4'h0;
            sw_s2_q     <= 4'h0;
            state_q     <= StIdle;
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            hour_q      <= 8'h00;
            presc_q     <= '0;
            alarm_cnt_q <= '0;
            buzz_cnt_q  <= '0;
            buzz_ph_q   <= 1'b0;
            buzzer      <= 1'b0;
            led         <= 3'b000;
            seg0        <= 7'b1000000;
            seg1        <= 7'b1000000;
            seg2        <= 7'b1000000;
            seg3        <= 7'b1000000;
            seg4        <= 7'b1000000;
            seg5        <= 7'b1000000;
        end else begin
            sw_s1_q     <= swtich;
            sw_s2_q     <= sw_s1_q;
            state_q     <= state_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            presc_q     <= presc_d;
            alarm_cnt_q <= alarm_cnt_d;
            buzz_cnt_q  <= buzz_cnt_d;
            buzz_ph_q   <= buzz_ph_d;
            buzzer      <= buzzer_d;
            led         <= led_d;
            seg0        <= bcd_to_seg(sec_q[3:0]);
            seg1        <= bcd_to_seg(sec_q[7:4]);
            seg2        <= bcd_to_seg(min_q[3:0]);
            seg3        <= bcd_to_seg(min_q[7:4]);
            seg4        <= bcd_to_seg(hour_q[3:0]);
            seg5        <= bcd_to_seg(hour_q[7:4]);
        end
    end

endmodule
